// File: rtl/dvp_pkg.sv
// Shared encodings and constants for the synthetic DVP (OV5642-style RGB565) source.
package dvp_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_e;

  localparam int NUM_BARS = 8;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [NUM_BARS-1:0][15:0] BAR_RGB565 = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  // Width of a counter that runs 0 .. max_count-1 (never narrower than one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern source: maps pixel coordinates and the latched
// selection to one RGB565 pixel.
module dvp_pattern_gen
  import dvp_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [5:0]  x_i,
  input  logic [3:0]  y_i,
  input  logic [2:0]  bar_i,
  input  logic [15:0] solid_i,
  output logic [15:0] pixel_o
);

  // Only bit 3 of the line matters (8x8 checker squares).
  logic unused_y;
  assign unused_y = ^y_i[2:0];

  always_comb begin
    pixel_o = 16'h0000;
    case (pattern_e'(sel_i))
      PAT_BARS:  pixel_o = BAR_RGB565[bar_i];
      PAT_RAMP:  pixel_o = {x_i[4:0], x_i, x_i[4:0]};
      PAT_CHECK: pixel_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
      PAT_SOLID: pixel_o = solid_i;
      default:   pixel_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// Synthetic DVP transmitter: frame timing FSM, line/pixel counters and RGB565
// byte serialisation; all outputs are registered off i_clk (the pixel clock).
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int H_BLANK     = 256,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 20,
  parameter int V_FRONT     = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern_sel,
  input  logic [15:0] i_solid_rgb565,
  output logic        o_dvp_vsync,
  output logic        o_dvp_href,
  output logic [7:0]  o_dvp_pdata,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int HC_W      = cnt_width(LINE_CLKS);
  localparam int LN_MAX    = max_int(max_int(VSYNC_LINES, V_BACK), max_int(V_ACTIVE, V_FRONT));
  localparam int LN_W      = cnt_width(LN_MAX);
  localparam int BAR_PX    = H_ACTIVE / NUM_BARS;
  localparam int BP_W      = cnt_width(BAR_PX);

  localparam logic [HC_W-1:0] HC_LAST     = HC_W'(LINE_CLKS - 1);
  localparam logic [HC_W-1:0] HC_HREF_END = HC_W'(2 * H_ACTIVE);
  localparam logic [BP_W-1:0] BP_LAST     = BP_W'(BAR_PX - 1);
  localparam logic [LN_W-1:0] VS_LAST     = LN_W'(max_int(VSYNC_LINES - 1, 0));
  localparam logic [LN_W-1:0] VB_LAST     = LN_W'(max_int(V_BACK - 1, 0));
  localparam logic [LN_W-1:0] VA_LAST     = LN_W'(max_int(V_ACTIVE - 1, 0));
  localparam logic [LN_W-1:0] VF_LAST     = LN_W'(max_int(V_FRONT - 1, 0));

  // Zero-length blanking states are skipped by routing around them.
  localparam state_e FIRST_STATE = (VSYNC_LINES > 0) ? ST_VSYNC :
                                   ((V_BACK > 0) ? ST_VBACK : ST_ACTIVE);
  localparam state_e AFTER_VSYNC = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
  localparam state_e LAST_STATE  = (V_FRONT > 0) ? ST_VFRONT : ST_ACTIVE;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic [LN_W-1:0] line_q, line_d, line_last;
  logic [2:0]      bar_q, bar_d;
  logic [BP_W-1:0] bar_px_q, bar_px_d;
  logic [1:0]      sel_q, sel_d;
  logic [15:0]     solid_q, solid_d;

  logic        line_end, state_last, frame_end, start_frame, in_href;
  logic [15:0] pixel;
  logic        vsync_d, href_d, busy_d, done_d;
  logic [7:0]  pdata_d;

  always_comb begin
    line_last = '0;
    case (state_q)
      ST_VSYNC:  line_last = VS_LAST;
      ST_VBACK:  line_last = VB_LAST;
      ST_ACTIVE: line_last = VA_LAST;
      ST_VFRONT: line_last = VF_LAST;
      default:   line_last = '0;
    endcase
  end

  assign line_end   = (hcnt_q == HC_LAST);
  assign state_last = line_end && (line_q == line_last);
  assign frame_end  = state_last && (state_q == LAST_STATE);
  assign in_href    = (state_q == ST_ACTIVE) && (hcnt_q < HC_HREF_END);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of block order.
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; enable is only looked at in IDLE and at the frame boundary.
  always_comb begin
    // NOTE: the default assignment first means no path leaves state_d unassigned, so no latch is inferred.
    state_d = state_q;
    if (frame_end) begin
      state_d = i_enable ? FIRST_STATE : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (i_enable)   state_d = FIRST_STATE;
        ST_VSYNC:  if (state_last) state_d = AFTER_VSYNC;
        ST_VBACK:  if (state_last) state_d = ST_ACTIVE;
        ST_ACTIVE: if (state_last) state_d = ST_VFRONT;
        ST_VFRONT: state_d = state_q;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign start_frame = (state_d != ST_IDLE) && ((state_q == ST_IDLE) || frame_end);

  // Counters and pattern latch. Bars are tracked by counting pixels per bar, avoiding a divider.
  always_comb begin
    hcnt_d   = '0;
    line_d   = '0;
    bar_d    = '0;
    bar_px_d = '0;
    sel_d    = start_frame ? i_pattern_sel  : sel_q;
    solid_d  = start_frame ? i_solid_rgb565 : solid_q;
    if (state_q != ST_IDLE) begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      line_d = state_last ? '0 : (line_end ? line_q + 1'b1 : line_q);
    end
    if (in_href) begin
      bar_d    = bar_q;
      bar_px_d = bar_px_q;
      if (hcnt_q[0]) begin
        if (bar_px_q == BP_LAST) begin
          bar_px_d = '0;
          bar_d    = bar_q + 1'b1;
        end else begin
          bar_px_d = bar_px_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q   <= '0;
      line_q   <= '0;
      bar_q    <= '0;
      bar_px_q <= '0;
      sel_q    <= '0;
      solid_q  <= '0;
    end else begin
      hcnt_q   <= hcnt_d;
      line_q   <= line_d;
      bar_q    <= bar_d;
      bar_px_q <= bar_px_d;
      sel_q    <= sel_d;
      solid_q  <= solid_d;
    end
  end

  dvp_pattern_gen u_pattern_gen (
    .sel_i   (sel_q),
    .x_i     (6'(hcnt_q >> 1)),
    .y_i     (4'(line_q)),
    .bar_i   (bar_q),
    .solid_i (solid_q),
    .pixel_o (pixel)
  );

  // Output decode; even byte of a pixel carries {R, G[5:3]}, odd byte {G[2:0], B}.
  always_comb begin
    vsync_d = (state_q == ST_VSYNC);
    href_d  = in_href;
    busy_d  = (state_q != ST_IDLE);
    done_d  = frame_end;
    pdata_d = '0;
    if (in_href) pdata_d = hcnt_q[0] ? pixel[7:0] : pixel[15:8];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dvp_vsync  <= 1'b0;
      o_dvp_href   <= 1'b0;
      o_dvp_pdata  <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_dvp_vsync  <= vsync_d;
      o_dvp_href   <= href_d;
      o_dvp_pdata  <= pdata_d;
      o_busy       <= busy_d;
      o_frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Self-checking bench for dvp_pattern_tx using a frame-position reference model
// plus a table of hand-computed pixel bytes.
module tb_dvp_pattern_tx;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * HA + HB;
  localparam int FR = L * (VS + VB + VA + VF);

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [1:0]  i_pattern_sel = 2'd0;
  logic [15:0] i_solid_rgb565 = 16'h0000;
  logic        o_dvp_vsync, o_dvp_href, o_busy, o_frame_done;
  logic [7:0]  o_dvp_pdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] cap [FR];
  logic [15:0] bar_rgb [8];

  typedef struct {
    int          sel;
    logic [15:0] solid;
    int          x;
    int          y;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  dvp_pattern_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_pattern_sel  (i_pattern_sel),
    .i_solid_rgb565 (i_solid_rgb565),
    .o_dvp_vsync    (o_dvp_vsync),
    .o_dvp_href     (o_dvp_href),
    .o_dvp_pdata    (o_dvp_pdata),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Packed view {vsync, href, pdata[7:0], busy, frame_done}.
  function automatic logic [11:0] sample_outs();
    return {o_dvp_vsync, o_dvp_href, o_dvp_pdata, o_busy, o_frame_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected outputs at clock k of a frame (k=0 is the first vsync-high clock).
  function automatic logic [11:0] model(input int k, input int sel, input logic [15:0] solid);
    int          line, h, x, y;
    logic        vs, hr, done;
    logic [15:0] pix;
    logic [7:0]  b;
    line = k / L;
    h    = k % L;
    x    = h / 2;
    y    = line - VS - VB;
    vs   = (line < VS);
    hr   = (y >= 0) && (y < VA) && (h < 2 * HA);
    pix  = 16'h0000;
    if (hr) begin
      case (sel)
        0:       pix = bar_rgb[x / (HA / 8)];
        1:       pix = 16'((x % 32) * 2048 + (x % 64) * 32 + (x % 32));
        2:       pix = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        default: pix = solid;
      endcase
    end
    b    = !hr ? 8'h00 : ((h % 2 == 0) ? pix[15:8] : pix[7:0]);
    done = (k == FR - 1);
    return {vs, hr, b, 1'b1, done};
  endfunction

  task automatic wait_vsync_rise(output int t);
    logic prev;
    bit   found;
    prev  = o_dvp_vsync;
    found = 1'b0;
    t     = -1;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge i_clk);
      if (o_dvp_vsync && !prev) begin
        found = 1'b1;
        t     = cyc;
      end
      prev = o_dvp_vsync;
    end
    if (!found) check("vsync_rise_timeout", 32'd0, 32'd1);
  endtask

  // Records one frame starting at the current (vsync-rise) sample; optionally
  // drops enable or changes the pattern inputs at given clocks of the frame.
  task automatic capture_frame(input int drop_k, input int chg_k,
                               input logic [1:0] chg_sel, input logic [15:0] chg_solid);
    for (int k = 0; k < FR; k++) begin
      if (k > 0) @(negedge i_clk);
      cap[k] = sample_outs();
      if (k == drop_k) i_enable = 1'b0;
      if (k == chg_k) begin
        i_pattern_sel  = chg_sel;
        i_solid_rgb565 = chg_solid;
      end
    end
  endtask

  task automatic compare_frame(input string tag, input int sel, input logic [15:0] solid);
    for (int k = 0; k < FR; k++)
      check($sformatf("%s k=%0d", tag, k), 32'(cap[k]), 32'(model(k, sel, solid)));
  endtask

  function automatic int count_bit(input int bitpos);
    int n = 0;
    for (int k = 0; k < FR; k++) if (cap[k][bitpos]) n++;
    return n;
  endfunction

  initial begin
    vec_t        vecs [9];
    int          t0, t1, k, act;
    logic [1:0]  fsel, nsel;
    logic [15:0] fsolid, nsolid;

    bar_rgb = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    vecs[0] = '{0, 16'h0000, 0, 0, 8'hFF, 8'hFF};
    vecs[1] = '{0, 16'h0000, 3, 2, 8'h07, 8'hE0};
    vecs[2] = '{0, 16'h0000, 5, 1, 8'hF8, 8'h00};
    vecs[3] = '{0, 16'h0000, 7, 3, 8'h00, 8'h00};
    vecs[4] = '{1, 16'h0000, 5, 1, 8'h28, 8'hA5};
    vecs[5] = '{1, 16'h0000, 7, 0, 8'h38, 8'hE7};
    vecs[6] = '{2, 16'h0000, 4, 3, 8'h00, 8'h00};
    vecs[7] = '{3, 16'hABCD, 2, 1, 8'hAB, 8'hCD};
    vecs[8] = '{3, 16'h1234, 6, 3, 8'h12, 8'h34};

    // Reset and idle.
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_outs", 32'(sample_outs()), 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check($sformatf("idle_outs%0d", i), 32'(sample_outs()), 32'd0);
    end

    // Single frames per table vector.
    for (int i = 0; i < 9; i++) begin
      i_pattern_sel  = 2'(vecs[i].sel);
      i_solid_rgb565 = vecs[i].solid;
      i_enable       = 1'b1;
      wait_vsync_rise(t0);
      capture_frame(5, -1, 2'd0, 16'h0000);
      compare_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].solid);
      k = (VS + VB + vecs[i].y) * L + 2 * vecs[i].x;
      check($sformatf("vec%0d_byte_hi", i), 32'(cap[k][9:2]), 32'(vecs[i].hi));
      check($sformatf("vec%0d_byte_lo", i), 32'(cap[k + 1][9:2]), 32'(vecs[i].lo));
      check($sformatf("vec%0d_vsync_clks", i), 32'(count_bit(11)), 32'd20);
      check($sformatf("vec%0d_done_last", i), 32'({cap[FR - 1][0], 8'(count_bit(0))}), 32'h101);
      repeat (3) @(negedge i_clk);
      check($sformatf("vec%0d_idle", i), 32'(sample_outs()), 32'd0);
    end

    // Stop: enable dropped during ACTIVE still completes the frame.
    i_pattern_sel = 2'd0;
    i_enable      = 1'b1;
    wait_vsync_rise(t0);
    capture_frame(60, -1, 2'd0, 16'h0000);
    compare_frame("stop", 0, 16'h0000);
    check("stop_done_count", 32'(count_bit(0)), 32'd1);
    act = 0;
    repeat (300) begin
      @(negedge i_clk);
      if (sample_outs() != 12'h000) act++;
    end
    check("stop_idle_activity", 32'(act), 32'd0);

    // Pattern latch: selection change mid-frame only affects the next frame.
    i_pattern_sel  = 2'd3;
    i_solid_rgb565 = 16'hABCD;
    i_enable       = 1'b1;
    wait_vsync_rise(t0);
    capture_frame(-1, 60, 2'd0, 16'h5A5A);
    compare_frame("latch_solid", 3, 16'hABCD);
    wait_vsync_rise(t1);
    check("latch_period", 32'(t1 - t0), 32'(FR));
    capture_frame(10, -1, 2'd0, 16'h0000);
    compare_frame("latch_bars", 0, 16'h0000);
    repeat (3) @(negedge i_clk);

    // Continuous run with random patterns, changed right after each frame starts.
    fsel           = 2'($urandom_range(0, 3));
    fsolid         = 16'($urandom);
    i_pattern_sel  = fsel;
    i_solid_rgb565 = fsolid;
    i_enable       = 1'b1;
    wait_vsync_rise(t0);
    for (int f = 0; f < 4; f++) begin
      nsel   = 2'($urandom_range(0, 3));
      nsolid = 16'($urandom);
      capture_frame((f == 3) ? 70 : -1, 1, nsel, nsolid);
      compare_frame($sformatf("run%0d", f), fsel, fsolid);
      if (f < 3) begin
        wait_vsync_rise(t1);
        check($sformatf("run%0d_period", f), 32'(t1 - t0), 32'(FR));
        t0 = t1;
      end
      fsel   = nsel;
      fsolid = nsolid;
    end
    repeat (3) @(negedge i_clk);

    // Reset during ACTIVE aborts the frame asynchronously.
    i_pattern_sel  = 2'd1;
    i_solid_rgb565 = 16'h0000;
    i_enable       = 1'b1;
    wait_vsync_rise(t0);
    repeat (60) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check("rst_async", 32'(sample_outs()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check($sformatf("rst_hold%0d", i), 32'(sample_outs()), 32'd0);
    end
    i_rst_n = 1'b1;
    wait_vsync_rise(t0);
    capture_frame(5, -1, 2'd0, 16'h0000);
    compare_frame("post_reset", 1, 16'h0000);
    repeat (3) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
